// File: rtl/ub_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ub_arb_pkg
// Description : Shared constants for the user bus arbiter. This package holds
//               the FSM state encoding, the data returned on a timed-out
//               access and the master index values.
// Revision    : 1.0 - initial release
// ============================================================================
package ub_arb_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Read data handed back when the slave never releases USER_WAIT
  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  // Master indices
  localparam logic M_A = 1'b0;
  localparam logic M_B = 1'b1;

  // One-hot GRANT encoding for a master index (bit0 = A, bit1 = B)
  function automatic logic [1:0] grant_onehot(input logic idx);
    return (idx == M_B) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ub_req_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ub_req_tracker
// Description : Per-master request qualifier. A master stays eligible only
//               until its access is acknowledged. After that it must drop
//               both RD and WR for at least one cycle before a new request
//               is accepted.
// Ports       : CLK, RSTb   - clock and async active-low reset
//               i_rd, i_wr  - master request levels
//               i_ack       - high on the edge that loads this master's ACK
//               o_pending   - master is requesting and not yet serviced
// Revision    : 1.0 - initial release
// ============================================================================
module ub_req_tracker (
  input  logic CLK,
  input  logic RSTb,
  input  logic i_rd,
  input  logic i_wr,
  input  logic i_ack,
  output logic o_pending
);

  logic r_done;

  // Setting the flag takes priority over clearing it. The request is always
  // still high on the acknowledge edge, so the two never actually collide.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_done <= 1'b0;
    end else if (i_ack) begin
      r_done <= 1'b1;
    end else if (!i_rd && !i_wr) begin
      r_done <= 1'b0;
    end
  end

  assign o_pending = (i_rd | i_wr) & ~r_done;

endmodule
`default_nettype wire

// File: rtl/user_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : user_bus_arbiter
// Description : Shares the board-local user register bus between master A
//               (VME slave) and master B (Aurora fiber bus). Each access runs
//               through SETUP, STROBE, WAIT and DONE. Simultaneous requests
//               are granted round-robin, and a hung slave is aborted with a
//               timeout.
// Ports       : CLK, RSTb                   - clock, async active-low reset
//               A_*/B_* RD,WR,ADDR,WDATA     - master requests (held to ACK)
//               A_*/B_* RDATA,ACK,ERR        - master completion outputs
//               USER_REb/WEb/OEb/ADDR/DATA_OUT - registered user bus drive
//               USER_DATA_IN, USER_WAIT      - slave read data, wait request
//               GRANT, BUSY                  - current owner, FSM active
// Revision    : 1.0 - initial release
// ============================================================================
module user_bus_arbiter
  import ub_arb_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        A_RD,
  input  logic        A_WR,
  input  logic [15:0] A_ADDR,
  input  logic [31:0] A_WDATA,
  output logic [31:0] A_RDATA,
  output logic        A_ACK,
  output logic        A_ERR,
  input  logic        B_RD,
  input  logic        B_WR,
  input  logic [15:0] B_ADDR,
  input  logic [31:0] B_WDATA,
  output logic [31:0] B_RDATA,
  output logic        B_ACK,
  output logic        B_ERR,
  output logic        USER_REb,
  output logic        USER_WEb,
  output logic        USER_OEb,
  output logic [15:0] USER_ADDR,
  output logic [31:0] USER_DATA_OUT,
  input  logic [31:0] USER_DATA_IN,
  input  logic        USER_WAIT,
  output logic [1:0]  GRANT,
  output logic        BUSY
);

  localparam logic [9:0] C_RD_MIN_M1 = 10'(RD_WAIT - 1);
  localparam logic [9:0] C_WR_MIN_M1 = 10'(WR_WAIT - 1);
  // The abort is taken on the edge where the counter would reach TIMEOUT-1,
  // so the access spends TIMEOUT-1 cycles in WAIT in total.
  localparam logic [9:0] C_TO_LAST   = 10'(TIMEOUT - 2);

  logic [2:0]  r_state;
  logic [9:0]  r_cnt;
  logic        r_is_wr;
  logic        r_owner;
  logic        r_last_grant;
  logic        r_re_n, r_we_n, r_oe_n;
  logic [15:0] r_addr;
  logic [31:0] r_dout;
  logic [31:0] r_a_rdata, r_b_rdata;
  logic        r_a_ack, r_b_ack, r_a_err, r_b_err;
  logic [1:0]  r_grant;
  logic        r_busy;

  logic        w_a_pend, w_b_pend;
  logic        w_pick_b, w_sel_wr;
  logic [15:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [9:0]  w_min_m1;
  logic        w_wait_ok, w_timeout, w_finish, w_ack_a, w_ack_b;

  ub_req_tracker u_trk_a (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .i_rd      (A_RD),
    .i_wr      (A_WR),
    .i_ack     (w_ack_a),
    .o_pending (w_a_pend)
  );

  ub_req_tracker u_trk_b (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .i_rd      (B_RD),
    .i_wr      (B_WR),
    .i_ack     (w_ack_b),
    .o_pending (w_b_pend)
  );

  always_comb begin
    // B wins if it is the only requester, or if both request and A went last
    w_pick_b    = w_b_pend & (~w_a_pend | (r_last_grant == M_A));
    // WR alone decides direction, so RD+WR together is a write
    w_sel_wr    = w_pick_b ? B_WR    : A_WR;
    w_sel_addr  = w_pick_b ? B_ADDR  : A_ADDR;
    w_sel_wdata = w_pick_b ? B_WDATA : A_WDATA;
    w_min_m1    = r_is_wr ? C_WR_MIN_M1 : C_RD_MIN_M1;
    w_wait_ok   = (r_cnt >= w_min_m1) && !USER_WAIT;
    w_timeout   = USER_WAIT && (r_cnt == C_TO_LAST);
    w_finish    = (r_state == ST_WAIT) && (w_wait_ok || w_timeout);
    w_ack_a     = w_finish && (r_owner == M_A);
    w_ack_b     = w_finish && (r_owner == M_B);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_is_wr      <= 1'b0;
      r_owner      <= M_A;
      r_last_grant <= M_B;
      r_re_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_addr       <= '0;
      r_dout       <= '0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_a_err      <= 1'b0;
      r_b_err      <= 1'b0;
      r_grant      <= 2'b00;
      r_busy       <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_a_pend || w_b_pend) begin
            r_owner <= w_pick_b;
            r_is_wr <= w_sel_wr;
            r_addr  <= w_sel_addr;
            r_dout  <= w_sel_wdata;
            // Output enable opens with SETUP so the decoder sees it early
            r_oe_n  <= w_sel_wr;
            r_grant <= grant_onehot(w_pick_b);
            r_busy  <= 1'b1;
            if (w_pick_b) r_b_err <= 1'b0;
            else          r_a_err <= 1'b0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_re_n  <= r_is_wr;
          r_we_n  <= ~r_is_wr;
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          r_re_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_wait_ok) begin
            if (!r_is_wr) begin
              if (r_owner == M_B) r_b_rdata <= USER_DATA_IN;
              else                r_a_rdata <= USER_DATA_IN;
            end
            r_a_ack <= w_ack_a;
            r_b_ack <= w_ack_b;
            r_oe_n  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            if (r_owner == M_B) begin
              r_b_rdata <= TIMEOUT_DATA;
              r_b_err   <= 1'b1;
            end else begin
              r_a_rdata <= TIMEOUT_DATA;
              r_a_err   <= 1'b1;
            end
            r_a_ack <= w_ack_a;
            r_b_ack <= w_ack_b;
            r_oe_n  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        ST_DONE: begin
          r_last_grant <= r_owner;
          r_grant      <= 2'b00;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign A_RDATA       = r_a_rdata;
  assign A_ACK         = r_a_ack;
  assign A_ERR         = r_a_err;
  assign B_RDATA       = r_b_rdata;
  assign B_ACK         = r_b_ack;
  assign B_ERR         = r_b_err;
  assign USER_REb      = r_re_n;
  assign USER_WEb      = r_we_n;
  assign USER_OEb      = r_oe_n;
  assign USER_ADDR     = r_addr;
  assign USER_DATA_OUT = r_dout;
  assign GRANT         = r_grant;
  assign BUSY          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_user_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_bus_arbiter
// Description : Directed self-checking bench for user_bus_arbiter. Cycle 0 is
//               the cycle in which a request is first presented. Outputs are
//               sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b1;
  logic        A_RD = 0, A_WR = 0, B_RD = 0, B_WR = 0;
  logic [15:0] A_ADDR = '0, B_ADDR = '0;
  logic [31:0] A_WDATA = '0, B_WDATA = '0;
  logic [31:0] A_RDATA, B_RDATA;
  logic        A_ACK, A_ERR, B_ACK, B_ERR;
  logic        USER_REb, USER_WEb, USER_OEb;
  logic [15:0] USER_ADDR;
  logic [31:0] USER_DATA_OUT;
  logic [31:0] USER_DATA_IN = '0;
  logic        USER_WAIT = 1'b0;
  logic [1:0]  GRANT;
  logic        BUSY;

  int n_chk = 0;
  int n_err = 0;

  // results of the last run_access
  int          res_ack_cyc, res_ack_cnt;
  logic [63:0] res_re, res_we, res_oe;
  logic [31:0] res_rdata, res_dout;
  logic [15:0] res_addr;
  logic        res_err, res_err1, res_busy1;
  logic [1:0]  res_g1;

  user_bus_arbiter #(.RD_WAIT(2), .WR_WAIT(1), .TIMEOUT(16)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .A_RD(A_RD), .A_WR(A_WR), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_RDATA(A_RDATA), .A_ACK(A_ACK), .A_ERR(A_ERR),
    .B_RD(B_RD), .B_WR(B_WR), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_RDATA(B_RDATA), .B_ACK(B_ACK), .B_ERR(B_ERR),
    .USER_REb(USER_REb), .USER_WEb(USER_WEb), .USER_OEb(USER_OEb),
    .USER_ADDR(USER_ADDR), .USER_DATA_OUT(USER_DATA_OUT),
    .USER_DATA_IN(USER_DATA_IN), .USER_WAIT(USER_WAIT),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTb = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RSTb = 1'b1;
  endtask

  // Presents one request at cycle 0 and follows it until two cycles past ACK.
  task automatic run_access(input bit is_b, input bit rd, input bit wr,
                            input logic [15:0] addr, input logic [31:0] wdata,
                            input int wait_from, input int wait_to,
                            input logic [31:0] din, input bit din_ramp, input bit hold);
    logic ackv;
    res_ack_cyc = -1; res_ack_cnt = 0;
    res_re = '0; res_we = '0; res_oe = '0;
    res_rdata = '0; res_dout = '0; res_addr = '0;
    res_err = 1'b0; res_err1 = 1'b0; res_busy1 = 1'b0; res_g1 = 2'b00;
    for (int cyc = 0; cyc < 48; cyc++) begin
      if (cyc > 0) tick();
      ackv = is_b ? B_ACK : A_ACK;
      if (!USER_REb) res_re[cyc] = 1'b1;
      if (!USER_WEb) begin
        res_we[cyc] = 1'b1;
        res_addr = USER_ADDR;
        res_dout = USER_DATA_OUT;
      end
      if (!USER_OEb) res_oe[cyc] = 1'b1;
      if (cyc == 1) begin
        res_g1 = GRANT; res_busy1 = BUSY;
        res_err1 = is_b ? B_ERR : A_ERR;
      end
      if (ackv) begin
        res_ack_cnt++;
        if (res_ack_cyc < 0) begin
          res_ack_cyc = cyc;
          res_rdata = is_b ? B_RDATA : A_RDATA;
          res_err = is_b ? B_ERR : A_ERR;
          if (!hold) begin
            if (is_b) begin B_RD = 0; B_WR = 0; end
            else      begin A_RD = 0; A_WR = 0; end
          end
        end
      end
      if (res_ack_cyc >= 0 && cyc >= res_ack_cyc + 2) break;
      USER_WAIT = (cyc >= wait_from) && (cyc <= wait_to);
      USER_DATA_IN = din_ramp ? din + 32'(cyc) : din;
      if (cyc == 0) begin
        if (is_b) begin B_RD = rd; B_WR = wr; B_ADDR = addr; B_WDATA = wdata; end
        else      begin A_RD = rd; A_WR = wr; A_ADDR = addr; A_WDATA = wdata; end
      end
    end
  endtask

  initial begin
    int na, nb, a_ack1, b_ack1, a_re, b_re, ng;
    logic [1:0] gseq [4];
    logic [1:0] prev_g;
    logic [31:0] b_rd1;
    logic flag;

    #2;
    do_reset();

    // ---- reset values ----
    check_value("rst_strobes", {USER_REb, USER_WEb, USER_OEb}, 3'b111);
    check_value("rst_addr", USER_ADDR, 0);
    check_value("rst_dout", USER_DATA_OUT, 0);
    check_value("rst_rdata", A_RDATA | B_RDATA, 0);
    check_value("rst_ack_err", {A_ACK, A_ERR, B_ACK, B_ERR}, 0);
    check_value("rst_grant_busy", {GRANT, BUSY}, 0);

    // ---- simultaneous requests out of reset, then round-robin ----
    A_WR = 1; A_ADDR = 16'h0010; A_WDATA = 32'h0000_0011;
    B_RD = 1; B_ADDR = 16'h0020;
    USER_WAIT = 0; USER_DATA_IN = 32'h5555_AAAA;
    na = 0; nb = 0; a_ack1 = -1; b_ack1 = -1; a_re = -1; b_re = -1; ng = 0;
    prev_g = 2'b00; b_rd1 = '0;
    for (int i = 0; i < 4; i++) gseq[i] = 2'b00;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) tick();
      if (GRANT != 2'b00 && prev_g == 2'b00 && ng < 4) begin
        gseq[ng] = GRANT; ng++;
      end
      prev_g = GRANT;
      if (A_ACK) begin
        na++;
        if (na == 1) a_ack1 = cyc;
        A_WR = 0;
        a_re = (na < 2) ? cyc + 1 : -1;
      end else if (cyc == a_re) A_WR = 1;
      if (B_ACK) begin
        nb++;
        if (nb == 1) begin b_ack1 = cyc; b_rd1 = B_RDATA; end
        B_RD = 0;
        b_re = (nb < 2) ? cyc + 1 : -1;
      end else if (cyc == b_re) B_RD = 1;
    end
    check_value("sim_a_ack_cycle", a_ack1, 4);
    check_value("sim_b_ack_cycle", b_ack1, 10);
    check_value("sim_b_rdata", b_rd1, 32'h5555_AAAA);
    check_value("rr_grant_count", ng, 4);
    check_value("rr_grant0", gseq[0], 2'b01);
    check_value("rr_grant1", gseq[1], 2'b10);
    check_value("rr_grant2", gseq[2], 2'b01);
    check_value("rr_grant3", gseq[3], 2'b10);

    do_reset();

    // ---- A write only ----
    run_access(0, 0, 1, 16'h0104, 32'h1234_5678, 99, 0, 32'h0, 0, 0);
    check_value("wr_grant_busy", {res_g1, res_busy1}, 3'b011);
    check_value("wr_web_mask", res_we[31:0], 32'h0000_0004);
    check_value("wr_reb_oeb_mask", res_re[31:0] | res_oe[31:0], 0);
    check_value("wr_addr", res_addr, 16'h0104);
    check_value("wr_dout", res_dout, 32'h1234_5678);
    check_value("wr_ack_cycle", res_ack_cyc, 4);
    check_value("wr_ack_pulses", res_ack_cnt, 1);
    check_value("wr_err", res_err, 0);

    // ---- B read ----
    run_access(1, 1, 0, 16'h0200, 32'h0, 99, 0, 32'hCAFE_0001, 0, 0);
    check_value("rd_grant", res_g1, 2'b10);
    check_value("rd_oeb_mask", res_oe[31:0], 32'h0000_001E);
    check_value("rd_reb_mask", res_re[31:0], 32'h0000_0004);
    check_value("rd_web_mask", res_we[31:0], 0);
    check_value("rd_ack_cycle", res_ack_cyc, 5);
    check_value("rd_ack_pulses", res_ack_cnt, 1);
    check_value("rd_rdata", res_rdata, 32'hCAFE_0001);

    // ---- wait states: USER_WAIT high for cycles 2..7 ----
    run_access(1, 1, 0, 16'h0208, 32'h0, 2, 7, 32'hBEEF_0000, 1, 0);
    check_value("ws_ack_cycle", res_ack_cyc, 9);
    check_value("ws_rdata", res_rdata, 32'hBEEF_0008);
    check_value("ws_err", res_err, 0);

    // ---- timeout with USER_WAIT stuck ----
    run_access(0, 1, 0, 16'h0300, 32'h0, 2, 1000, 32'h0000_0001, 0, 0);
    check_value("to_ack_cycle", res_ack_cyc, 18);
    check_value("to_err", res_err, 1);
    check_value("to_rdata", res_rdata, 32'hFFFF_FFFF);
    check_value("to_err_hold", {A_ERR, A_RDATA}, {1'b1, 32'hFFFF_FFFF});
    run_access(0, 0, 1, 16'h0304, 32'h0000_00AB, 99, 0, 32'h0, 0, 0);
    check_value("to_err_clr_at_grant", {res_g1, res_err1}, 3'b010);
    check_value("to_next_ack", {res_ack_cyc[7:0], res_err}, {8'd4, 1'b0});

    // ---- held request is not re-serviced ----
    run_access(0, 1, 0, 16'h0400, 32'h0, 99, 0, 32'h0000_0077, 0, 1);
    check_value("hold_first_ack", res_ack_cyc, 5);
    flag = 1'b0;
    repeat (6) begin
      tick();
      flag = flag | BUSY | A_ACK;
    end
    check_value("hold_no_regrant", flag, 0);
    A_RD = 0;
    tick();
    run_access(0, 1, 0, 16'h0400, 32'h0, 99, 0, 32'h0000_0078, 0, 0);
    check_value("hold_regrant", {res_g1, res_ack_cyc[7:0]}, {2'b01, 8'd5});
    check_value("hold_rdata", res_rdata, 32'h0000_0078);

    // ---- reset pulsed during WAIT ----
    A_RD = 1; A_ADDR = 16'h0500; USER_WAIT = 1;
    repeat (4) tick();
    check_value("mid_busy_before", {BUSY, GRANT}, 3'b101);
    RSTb = 1'b0;
    #1;
    check_value("mid_strobes", {USER_REb, USER_WEb, USER_OEb}, 3'b111);
    check_value("mid_grant_busy", {GRANT, BUSY}, 0);
    check_value("mid_ack_rdata", {A_ACK, A_RDATA}, 0);
    A_RD = 0; USER_WAIT = 0;
    tick();
    RSTb = 1'b1;
    flag = 1'b0;
    repeat (10) begin
      tick();
      flag = flag | A_ACK | B_ACK;
    end
    check_value("mid_no_ack", flag, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
